// File: rtl/vga_axil_regfile.sv
// AXI4-Lite slave register bank holding the VGA control/status registers.
// Writes use independent single-entry AW and W holding slots so either channel may arrive
// first; a write commits once both slots are full and the B channel can take the response.
// Reads complete with one cycle of latency. Read-only registers (RO_MASK) return ro_val_i.
//
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   aw*/w*/b*            AXI-Lite write address, write data and write response channels
//   ar*/r*               AXI-Lite read address and read data channels
//   regs_o               flat register contents, register i at [i*DATA_W +: DATA_W]
//   ro_val_i             hardware values returned for read-only registers
//   wr_pulse_o           one-cycle pulse per register committed by an OKAY write
module vga_axil_regfile #(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [DATA_W-1:0]    REG_RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_val_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int unsigned       BYTES    = DATA_W / 8;
    localparam int unsigned       OFF_W    = $clog2(BYTES);
    localparam int unsigned       IDX_W    = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(NUM_REGS * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic                       ready_en_q;
    logic                       aw_full_q, aw_full_d;
    logic [ADDR_W-1:0]          aw_addr_q, aw_addr_d;
    logic                       w_full_q, w_full_d;
    logic [DATA_W-1:0]          w_data_q, w_data_d;
    logic [BYTES-1:0]           w_strb_q, w_strb_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       rvalid_q, rvalid_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]        wr_pulse_q, wr_pulse_d;

    logic             commit, aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic [1:0]       wr_resp, rd_resp;

    // Handshakes and write decode; decode looks only at the held AW slot.
    always_comb begin
        commit  = aw_full_q && w_full_q && (!bvalid_q || bready);
        awready = ready_en_q && (!aw_full_q || commit);
        wready  = ready_en_q && (!w_full_q || commit);
        arready = ready_en_q && (!rvalid_q || rready);
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        ar_hs   = arvalid && arready;

        aw_idx = aw_addr_q[OFF_W +: IDX_W];
        ar_idx = araddr[OFF_W +: IDX_W];

        wr_resp = RESP_OKAY;
        if (aw_addr_q >= ADDR_END) begin
            wr_resp = RESP_DECERR;
        end else if (RO_MASK[aw_idx]) begin
            wr_resp = RESP_SLVERR;
        end

        rd_resp = (araddr >= ADDR_END) ? RESP_DECERR : RESP_OKAY;
    end

    // Holding slots: a slot drains on commit and may be refilled in the same cycle.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
    end

    // Register update, write pulse and B channel.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        if (bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
            if (wr_resp == RESP_OKAY) begin
                wr_pulse_d[aw_idx] = 1'b1;
                for (int unsigned k = 0; k < BYTES; k++) begin
                    if (w_strb_q[k]) begin
                        regs_d[int'(aw_idx) * DATA_W + k * 8 +: 8] = w_data_q[k * 8 +: 8];
                    end
                end
            end
        end
    end

    // R channel; data is captured from regs_q, so a same-cycle write commit is not visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_resp;
            if (rd_resp == RESP_DECERR) begin
                rdata_d = '0;
            end else if (RO_MASK[ar_idx]) begin
                rdata_d = ro_val_i[int'(ar_idx) * DATA_W +: DATA_W];
            end else begin
                rdata_d = regs_q[int'(ar_idx) * DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            regs_q     <= {NUM_REGS{REG_RST_VAL}};
            wr_pulse_q <= '0;
        end else begin
            ready_en_q <= 1'b1;
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign bvalid     = bvalid_q;
    assign bresp      = bresp_q;
    assign rvalid     = rvalid_q;
    assign rresp      = rresp_q;
    assign rdata      = rdata_q;
    assign regs_o     = regs_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile: 16 x 32-bit registers, register 7 read-only.
module tb_vga_axil_regfile;

    localparam logic [15:0] RO_MASK = 16'h0080;
    localparam logic [31:0] RO_VAL7 = 32'hCAFE_F00D;
    localparam logic [31:0] RO_VAL3 = 32'h3333_3333; // not read-only, must never be returned

    logic          clk = 1'b0;
    logic          arst;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;
    logic [511:0]  regs_o, ro_val;
    logic [15:0]   wr_pulse_o;

    int            total = 0;
    int            bad = 0;
    logic [31:0]   exp_regs [16];

    always #5 clk = ~clk;

    vga_axil_regfile #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NUM_REGS    (16),
        .RO_MASK     (RO_MASK),
        .REG_RST_VAL (32'h0)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .regs_o     (regs_o),
        .ro_val_i   (ro_val),
        .wr_pulse_o (wr_pulse_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full write with AW and W presented together and bready held high.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [15:0] pulses);
        bit aw_done = 0;
        bit w_done = 0;
        bit b_done = 0;
        resp = 2'bxx;
        pulses = '0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int c = 0; c < 20 && !b_done; c++) begin
            #1;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            if (bvalid) begin b_done = 1; resp = bresp; end
            step();
            pulses |= wr_pulse_o;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (!b_done) begin
            $display("FAIL write_timeout addr=%h: got no B response, required one", addr);
            bad++;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        bit ar_done = 0;
        bit r_done = 0;
        data = 'x;
        resp = 2'bxx;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        for (int c = 0; c < 20 && !r_done; c++) begin
            #1;
            if (arvalid && arready) ar_done = 1;
            if (rvalid) begin r_done = 1; data = rdata; resp = rresp; end
            step();
            if (ar_done) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        total++;
        if (!r_done) begin
            $display("FAIL read_timeout addr=%h: got no R response, required one", addr);
            bad++;
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        total += 6;
        if (awready !== 0) begin $display("FAIL rst_awready got=%b req=0", awready); bad++; end
        if (wready !== 0) begin $display("FAIL rst_wready got=%b req=0", wready); bad++; end
        if (arready !== 0) begin $display("FAIL rst_arready got=%b req=0", arready); bad++; end
        if (bvalid !== 0 || rvalid !== 0) begin
            $display("FAIL rst_valids got b=%b r=%b req=0", bvalid, rvalid); bad++;
        end
        if (wr_pulse_o !== 0) begin $display("FAIL rst_pulse got=%h req=0", wr_pulse_o); bad++; end
        if (regs_o !== '0) begin $display("FAIL rst_regs got=%h req=0", regs_o); bad++; end
        arst = 1'b0;
        #1;
        total++;
        if (arready !== 0) begin $display("FAIL ready_en_early got=%b req=0", arready); bad++; end
        @(posedge clk); #1;
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            $display("FAIL ready_en_rise got=%b req=111", {awready, wready, arready}); bad++;
        end
        // Read reg 3 and check one-cycle latency.
        araddr = 32'hC; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        total += 2;
        if (rvalid !== 1) begin $display("FAIL rd3_latency got rvalid=%b req=1", rvalid); bad++; end
        if (rdata !== 32'h0 || rresp !== 2'b00) begin
            $display("FAIL rd3_data got=%h/%b req=00000000/00", rdata, rresp); bad++;
        end
        rready = 1'b1;
        step();
        total++;
        if (rvalid !== 0) begin $display("FAIL rd3_drop got rvalid=%b req=0", rvalid); bad++; end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        awaddr = 32'h8; wdata = 32'hDEAD_BEEF; wstrb = 4'b0101;
        awvalid = 1; wvalid = 1; bready = 1;
        step();
        awvalid = 0; wvalid = 0;
        total++;
        if (wr_pulse_o !== 0 || bvalid !== 0) begin
            $display("FAIL strb_early got pulse=%h b=%b req=0/0", wr_pulse_o, bvalid); bad++;
        end
        step();
        total += 3;
        if (wr_pulse_o !== 16'h0004) begin
            $display("FAIL strb_pulse got=%h req=0004", wr_pulse_o); bad++;
        end
        if (bvalid !== 1 || bresp !== 2'b00) begin
            $display("FAIL strb_b got=%b/%b req=1/00", bvalid, bresp); bad++;
        end
        if (regs_o[2*32 +: 32] !== 32'h00AD_00EF) begin
            $display("FAIL strb_reg2 got=%h req=00ad00ef", regs_o[2*32 +: 32]); bad++;
        end
        step();
        total++;
        if (wr_pulse_o !== 0 || bvalid !== 0) begin
            $display("FAIL strb_one_cycle got pulse=%h b=%b req=0/0", wr_pulse_o, bvalid); bad++;
        end
        exp_regs[2] = 32'h00AD_00EF;
        do_read(32'h8, d, r);
        total++;
        if (d !== 32'h00AD_00EF || r !== 2'b00) begin
            $display("FAIL strb_read got=%h/%b req=00ad00ef/00", d, r); bad++;
        end
        do_read(32'hB, d, r);
        total++;
        if (d !== 32'h00AD_00EF || r !== 2'b00) begin
            $display("FAIL unaligned_read got=%h/%b req=00ad00ef/00", d, r); bad++;
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        logic [15:0] p;
        int          nb;
        int          np;
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1; bready = 1;
        step();
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (wready !== 0 || awready !== 1 || bvalid !== 0 || wr_pulse_o !== 0) begin
                $display("FAIL w_first_wait got wr=%b awr=%b b=%b p=%h req=0/1/0/0",
                         wready, awready, bvalid, wr_pulse_o);
                bad++;
            end
            step();
        end
        awaddr = 32'h14; awvalid = 1;
        step();
        awvalid = 0;
        step();
        total++;
        if (bvalid !== 1 || bresp !== 2'b00 || wr_pulse_o !== 16'h0020) begin
            $display("FAIL w_first_commit got b=%b/%b p=%h req=1/00/0020", bvalid, bresp,
                     wr_pulse_o);
            bad++;
        end
        exp_regs[5] = 32'h1122_3344;
        step();
        do_read(32'h14, d, r);
        total++;
        if (d !== 32'h1122_3344) begin $display("FAIL w_first_read got=%h req=11223344", d); bad++; end
        // AW and W together.
        do_write(32'h14, 32'hA0B0_C0D0, 4'hF, r, p);
        exp_regs[5] = 32'hA0B0_C0D0;
        total++;
        if (r !== 2'b00 || p !== 16'h0020) begin
            $display("FAIL same_cycle_aw_w got=%b/%h req=00/0020", r, p); bad++;
        end
        // Four back-to-back writes to regs 8..11.
        nb = 0; np = 0;
        awvalid = 1; wvalid = 1; wstrb = 4'hF; bready = 1;
        for (int i = 0; i < 4; i++) begin
            awaddr = (8 + i) * 4;
            wdata = 32'h8000_0000 | (8 + i);
            #1;
            total++;
            if (awready !== 1 || wready !== 1) begin
                $display("FAIL b2b_ready beat=%0d got=%b%b req=11", i, awready, wready); bad++;
            end
            step();
            nb += int'(bvalid);
            np += $countones(wr_pulse_o);
        end
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            nb += int'(bvalid);
            np += $countones(wr_pulse_o);
        end
        total++;
        if (nb != 4 || np != 4) begin
            $display("FAIL b2b_count got b=%0d pulses=%0d req=4/4", nb, np); bad++;
        end
        for (int i = 8; i < 12; i++) begin
            exp_regs[i] = 32'h8000_0000 | i;
            total++;
            if (regs_o[i*32 +: 32] !== exp_regs[i]) begin
                $display("FAIL b2b_reg%0d got=%h req=%h", i, regs_o[i*32 +: 32], exp_regs[i]);
                bad++;
            end
        end
    endtask

    task automatic test_backpressure();
        bready = 0;
        awaddr = 32'h40; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step();
        awaddr = 32'h34; wdata = 32'h1313_1313;
        #1;
        total++;
        if (awready !== 1 || wready !== 1) begin
            $display("FAIL bp_second_accept got=%b%b req=11", awready, wready); bad++;
        end
        step();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (bvalid !== 1 || bresp !== 2'b11 || awready !== 0 || wready !== 0 ||
                wr_pulse_o !== 0) begin
                $display("FAIL bp_hold cyc=%0d got b=%b/%b rdy=%b%b p=%h req=1/11/00/0000", i,
                         bvalid, bresp, awready, wready, wr_pulse_o);
                bad++;
            end
            step();
        end
        bready = 1;
        #1;
        total++;
        if (awready !== 1) begin $display("FAIL bp_release_ready got=%b req=1", awready); bad++; end
        step();
        exp_regs[13] = 32'h1313_1313;
        total += 2;
        if (bvalid !== 1 || bresp !== 2'b00 || wr_pulse_o !== 16'h2000) begin
            $display("FAIL bp_second_b got=%b/%b p=%h req=1/00/2000", bvalid, bresp, wr_pulse_o);
            bad++;
        end
        if (regs_o[0 +: 32] !== 32'h0 || regs_o[13*32 +: 32] !== exp_regs[13]) begin
            $display("FAIL bp_regs got r0=%h r13=%h req=00000000/13131313", regs_o[0 +: 32],
                     regs_o[13*32 +: 32]);
            bad++;
        end
        step();
        total++;
        if (bvalid !== 0) begin $display("FAIL bp_b_drop got=%b req=0", bvalid); bad++; end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r;
        logic [15:0] p;
        do_write(32'h7C, 32'hFFFF_FFFF, 4'hF, r, p);
        total++;
        if (r !== 2'b11 || p !== 0) begin $display("FAIL decerr_wr got=%b/%h req=11/0000", r, p); bad++; end
        do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, r, p);
        total++;
        if (r !== 2'b10 || p !== 0) begin $display("FAIL slverr_wr got=%b/%h req=10/0000", r, p); bad++; end
        do_read(32'h1C, d, r);
        total++;
        if (d !== RO_VAL7 || r !== 2'b00) begin
            $display("FAIL ro_read got=%h/%b req=%h/00", d, r, RO_VAL7); bad++;
        end
        do_read(32'h48, d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b11) begin $display("FAIL decerr_rd got=%h/%b req=0/11", d, r); bad++; end
        do_write(32'h3F, 32'hF00D_F00D, 4'hF, r, p);
        exp_regs[15] = 32'hF00D_F00D;
        total++;
        if (r !== 2'b00 || p !== 16'h8000) begin $display("FAIL last_reg_wr got=%b/%h req=00/8000", r, p); bad++; end
        do_read(32'h3C, d, r);
        total++;
        if (d !== 32'hF00D_F00D || r !== 2'b00) begin
            $display("FAIL last_reg_rd got=%h/%b req=f00df00d/00", d, r); bad++;
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (regs_o[i*32 +: 32] !== exp_regs[i]) begin
                $display("FAIL model_reg%0d got=%h req=%h", i, regs_o[i*32 +: 32], exp_regs[i]);
                bad++;
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] d;
        logic [1:0]  r;
        awaddr = 32'h10; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        bready = 1;
        step();
        awvalid = 0; wvalid = 0;
        araddr = 32'h10; arvalid = 1; rready = 1;
        #1;
        total++;
        if (arready !== 1) begin $display("FAIL rw_arready got=%b req=1", arready); bad++; end
        step();
        arvalid = 0;
        total++;
        if (rvalid !== 1 || rdata !== 32'h0 || wr_pulse_o !== 16'h0010) begin
            $display("FAIL rw_pre_value got r=%b d=%h p=%h req=1/00000000/0010", rvalid, rdata,
                     wr_pulse_o);
            bad++;
        end
        step();
        exp_regs[4] = 32'h5555_5555;
        do_read(32'h10, d, r);
        total++;
        if (d !== 32'h5555_5555) begin $display("FAIL rw_post_value got=%h req=55555555", d); bad++; end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        bready = 0; rready = 0;
        awaddr = 32'h4; wdata = 32'h0101_0101; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wdata = 32'h7777_7777;
        araddr = 32'h8; arvalid = 1;
        step();
        wvalid = 0; arvalid = 0;
        total++;
        if (bvalid !== 1 || rvalid !== 1 || wr_pulse_o !== 16'h0002) begin
            $display("FAIL mid_setup got b=%b r=%b p=%h req=1/1/0002", bvalid, rvalid, wr_pulse_o);
            bad++;
        end
        #1;
        arst = 1;
        #1;
        total += 3;
        if (bvalid !== 0 || rvalid !== 0 || wr_pulse_o !== 0) begin
            $display("FAIL mid_drop got b=%b r=%b p=%h req=0/0/0", bvalid, rvalid, wr_pulse_o);
            bad++;
        end
        if ({awready, wready, arready} !== 3'b000) begin
            $display("FAIL mid_ready got=%b req=000", {awready, wready, arready}); bad++;
        end
        if (regs_o !== '0) begin $display("FAIL mid_regs got=%h req=0", regs_o); bad++; end
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        step();
        arst = 0; bready = 1; rready = 1;
        step();
        awaddr = 32'h18; awvalid = 1;
        #1;
        total++;
        if (awready !== 1) begin $display("FAIL mid_aw_ready got=%b req=1", awready); bad++; end
        step();
        awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bvalid !== 0 || rvalid !== 0 || wr_pulse_o !== 0) begin
                $display("FAIL mid_stale cyc=%0d got b=%b r=%b p=%h req=0/0/0", i, bvalid,
                         rvalid, wr_pulse_o);
                bad++;
            end
            step();
        end
        wdata = 32'h6666_6666; wstrb = 4'hF; wvalid = 1;
        step();
        wvalid = 0;
        step();
        exp_regs[6] = 32'h6666_6666;
        total++;
        if (bvalid !== 1 || regs_o[6*32 +: 32] !== exp_regs[6]) begin
            $display("FAIL mid_fresh_write got b=%b r6=%h req=1/66666666", bvalid,
                     regs_o[6*32 +: 32]);
            bad++;
        end
        step();
        do_read(32'h4, d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b00) begin $display("FAIL mid_reg1 got=%h/%b req=0/00", d, r); bad++; end
    endtask

    initial begin
        ro_val = '0;
        ro_val[7*32 +: 32] = RO_VAL7;
        ro_val[3*32 +: 32] = RO_VAL3;
        test_reset();
        test_strobe();
        test_w_before_aw();
        test_backpressure();
        test_errors();
        test_same_cycle_rw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
